// File: rtl/ibexc_tsmap_arbiter_if.sv
// System-bus port of the TS map arbiter: request/grant
// handshake plus the one-cycle-later response.
interface ibexc_tsmap_arbiter_if #(
    parameter int unsigned AddrW = 16
) ();
    logic             req;
    logic             we;
    logic [AddrW-1:0] addr;
    logic [31:0]      wdata;
    logic [3:0]       be;
    logic             gnt;
    logic             rvalid;
    logic [31:0]      rdata;
    logic             err;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/ibexc_tsmap_arbiter.sv
// Shares the single-port TS map SRAM between the core read port,
// the system bus and a bulk-clear engine (core > bus > clear).
module ibexc_tsmap_arbiter #(
    parameter int unsigned TSMapSize    = 1024,
    parameter int unsigned AddrW        = 16,
    parameter int unsigned ClrStarveMax = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 core_cs_i,
    input  logic [AddrW-1:0]     core_addr_i,
    output logic [31:0]          core_rdata_o,
    ibexc_tsmap_arbiter_if.slave bus,
    input  logic                 clr_start_i,
    input  logic [AddrW-1:0]     clr_base_i,
    input  logic [AddrW:0]       clr_len_i,
    output logic                 clr_busy_o,
    output logic                 clr_done_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrW-1:0]     mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic [31:0]          mem_wmask_o,
    input  logic [31:0]          mem_rdata_i
);
    localparam int unsigned CntW = $clog2(ClrStarveMax + 1);
    localparam logic [AddrW:0] MapSize = (AddrW+1)'(TSMapSize);
    localparam logic [CntW-1:0] StarveMax = CntW'(ClrStarveMax);

    typedef enum logic [1:0] {IDLE, RUN, DONE} clr_state_e;

    clr_state_e       state_q, state_d;
    logic [AddrW-1:0] ptr_q, ptr_d;
    logic [AddrW:0]   rem_q, rem_d;
    logic [CntW-1:0]  starve_q, starve_d;
    logic [AddrW:0]   room;
    logic             starve_block, bus_in_range, clr_issue;
    logic             rvalid_q, err_q, rd_own_q;

    // Starvation relief only matters while the clear is waiting.
    assign starve_block = (state_q == RUN) && (starve_q == StarveMax);
    assign bus.gnt      = bus.req & ~core_cs_i & ~starve_block;
    assign bus_in_range = {1'b0, bus.addr} < MapSize;
    assign clr_issue    = (state_q == RUN) & ~core_cs_i & ~bus.gnt;
    assign room         = MapSize - {1'b0, clr_base_i};

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        unique case (1'b1)
            core_cs_i: begin
                mem_req_o  = 1'b1;
                mem_addr_o = core_addr_i;
            end
            bus.gnt & bus_in_range: begin
                mem_req_o   = 1'b1;
                mem_we_o    = bus.we;
                mem_addr_o  = bus.addr;
                mem_wdata_o = bus.wdata;
                mem_wmask_o = {{8{bus.be[3]}}, {8{bus.be[2]}},
                               {8{bus.be[1]}}, {8{bus.be[0]}}};
            end
            clr_issue: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = ptr_q;
                mem_wmask_o = '1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        starve_d = starve_q;
        unique case (state_q)
            IDLE: begin
                if (clr_start_i) begin
                    if ((clr_len_i != '0) && ({1'b0, clr_base_i} < MapSize)) begin
                        ptr_d   = clr_base_i;
                        // Clamp to the map end so ptr never leaves the map.
                        rem_d   = (clr_len_i < room) ? clr_len_i : room;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (clr_issue) begin
                    ptr_d    = ptr_q + 1'b1;
                    rem_d    = rem_q - 1'b1;
                    starve_d = '0;
                    if (rem_q == (AddrW+1)'(1)) state_d = DONE;
                end else if (starve_q != StarveMax) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            rem_q    <= '0;
            starve_q <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_own_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            starve_q <= starve_d;
            rvalid_q <= bus.gnt;
            err_q    <= bus.gnt & ~bus_in_range;
            rd_own_q <= bus.gnt & bus_in_range & ~bus.we;
        end
    end

    assign bus.rvalid   = rvalid_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rd_own_q ? mem_rdata_i : '0;
    assign core_rdata_o = mem_rdata_i;
    assign clr_busy_o   = (state_q != IDLE);
    assign clr_done_o   = (state_q == DONE);
endmodule

// File: tb/tb_ibexc_tsmap_arbiter.sv
// Directed bench for ibexc_tsmap_arbiter with an SRAM model
// and a response scoreboard for the bus port.
module tb_ibexc_tsmap_arbiter;
    localparam int MapSz = 1024;
    localparam int AW    = 16;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_cs = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [31:0]   core_rdata;
    logic          clr_start = 1'b0;
    logic [AW-1:0] clr_base = '0;
    logic [AW:0]   clr_len = '0;
    logic          clr_busy, clr_done;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_wmask;
    logic [31:0]   mem_rdata = '0;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    rsp_t        rsp_q[$];
    logic [31:0] sram[MapSz];
    bit          sram_wr[MapSz];
    logic [31:0] exp_data[MapSz];
    bit          exp_wr[MapSz];

    always #5 clk = ~clk;

    ibexc_tsmap_arbiter_if #(.AddrW(AW)) bus ();

    ibexc_tsmap_arbiter #(
        .TSMapSize(MapSz), .AddrW(AW), .ClrStarveMax(8)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .core_cs_i(core_cs), .core_addr_i(core_addr),
        .core_rdata_o(core_rdata),
        .bus(bus),
        .clr_start_i(clr_start), .clr_base_i(clr_base),
        .clr_len_i(clr_len), .clr_busy_o(clr_busy),
        .clr_done_o(clr_done),
        .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_wmask_o(mem_wmask), .mem_rdata_i(mem_rdata)
    );

    function automatic logic [31:0] init_val(input int a);
        case (a)
            1:       return 32'h1234_5678;
            5:       return 32'hDEAD_BEEF;
            default: return {a[7:0], ~a[7:0], a[7:0], 8'h5A};
        endcase
    endfunction

    // Single-port SRAM with one-cycle read latency and bit-masked writes
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                sram[mem_addr[9:0]] <= ((sram_wr[mem_addr[9:0]] ? sram[mem_addr[9:0]]
                                        : init_val(int'(mem_addr[9:0]))) & ~mem_wmask)
                                       | (mem_wdata & mem_wmask);
                sram_wr[mem_addr[9:0]] <= 1'b1;
            end else begin
                mem_rdata <= sram_wr[mem_addr[9:0]] ? sram[mem_addr[9:0]]
                             : init_val(int'(mem_addr[9:0]));
            end
        end
    end

    function automatic logic [31:0] exp_word(input int a);
        return exp_wr[a] ? exp_data[a] : init_val(a);
    endfunction

    task automatic exp_set(input int a, input logic [31:0] d);
        exp_data[a] = d;
        exp_wr[a]   = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rsp_pop(input string tag);
        rsp_t r;
        if (rsp_q.size() == 0) begin
            chk({tag, "_unexpected_rsp"}, 1, 0);
        end else begin
            r = rsp_q.pop_front();
            chk({tag, "_err"}, bus.err, r.err);
            chk({tag, "_rdata"}, bus.rdata, r.rdata);
        end
    endtask

    task automatic bus_xfer(input logic we, input logic [AW-1:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
        bit          ok;
        bit          inr;
        logic [31:0] m;
        ok = 0;
        bus.req = 1'b1; bus.we = we; bus.addr = a;
        bus.wdata = wd; bus.be = be;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.gnt) begin
                ok = 1;
                break;
            end
            @(posedge clk);
        end
        chk("bus_gnt", ok, 1);
        if (!ok) begin
            bus.req = 1'b0;
            return;
        end
        inr = int'(a) < MapSz;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        chk("bus_mem_req", mem_req, inr);
        if (inr) begin
            chk("bus_mem_addr", mem_addr, a);
            chk("bus_mem_we", mem_we, we);
            if (we) begin
                chk("bus_wmask", mem_wmask, m);
                chk("bus_wdata", mem_wdata, wd);
            end
        end
        rsp_q.push_back('{err: !inr,
                          rdata: (inr && !we) ? exp_word(int'(a)) : 32'h0});
        if (inr && we) exp_set(int'(a), (exp_word(int'(a)) & ~m) | (wd & m));
        step();
        bus.req = 1'b0;
        #1;
        chk("bus_rvalid", bus.rvalid, 1);
        rsp_pop("bus");
    endtask

    initial begin : main
        int          wq[$];
        int          writes;
        int          hits;
        bit          done_seen;
        bit          exp_g;
        bit          exp_w;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0;
        bus.wdata = '0; bus.be = '0;

        // Reset state
        repeat (2) step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_busy", clr_busy, 0);
        chk("rst_done", clr_done, 0);
        chk("rst_core_rdata", core_rdata, 0);
        rst = 1'b0;
        step();

        // Core read wins over a pending bus request
        core_cs = 1'b1; core_addr = 16'd5;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'd1;
        #1;
        chk("core_gnt_blocked", bus.gnt, 0);
        chk("core_mem_req", mem_req, 1);
        chk("core_mem_we", mem_we, 0);
        chk("core_mem_addr", mem_addr, 5);
        step();
        core_cs = 1'b0;
        chk("core_rdata", core_rdata, 32'hDEAD_BEEF);
        bus_xfer(1'b0, 16'd1, 32'h0, 4'h0);

        // Byte-masked write, read-back, out-of-range accesses
        bus_xfer(1'b1, 16'd3, 32'hAABB_CCDD, 4'b0010);
        chk("wmask_last", mem_wmask, 0);
        bus_xfer(1'b0, 16'd3, 32'h0, 4'h0);
        bus_xfer(1'b1, 16'd9, 32'h0102_0304, 4'b1001);
        bus_xfer(1'b0, 16'd9, 32'h0, 4'h0);
        bus_xfer(1'b0, 16'd1024, 32'h0, 4'h0);
        bus_xfer(1'b1, 16'd2000, 32'hFFFF_FFFF, 4'hF);

        // Clear clamped at the map end
        clr_base = 16'd1020; clr_len = 17'd10; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        chk("clr_busy_start", clr_busy, 1);
        for (int a = 1020; a < 1024; a++) wq.push_back(a);
        writes = 0;
        done_seen = 0;
        for (int i = 0; i < 20 && !done_seen; i++) begin
            if (mem_req && mem_we) begin
                writes++;
                chk("clr_addr", mem_addr, (wq.size() != 0) ? wq.pop_front() : -1);
                chk("clr_wmask", mem_wmask, 32'hFFFF_FFFF);
                chk("clr_wdata", mem_wdata, 0);
                exp_set(int'(mem_addr[9:0]), 32'h0);
            end
            if (clr_done) done_seen = 1;
            else step();
        end
        chk("clr_done_seen", done_seen, 1);
        chk("clr_write_count", writes, 4);
        chk("clr_busy_at_done", clr_busy, 1);
        step();
        chk("clr_busy_after", clr_busy, 0);
        chk("clr_done_after", clr_done, 0);
        bus_xfer(1'b0, 16'd1023, 32'h0, 4'h0);
        bus_xfer(1'b0, 16'd1019, 32'h0, 4'h0);

        // Clear starved by a continuous bus requester
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'd7;
        clr_base = 16'd10; clr_len = 17'd2; clr_start = 1'b1;
        #1;
        chk("starve_idle_gnt", bus.gnt, 1);
        rsp_q.push_back('{err: 1'b0, rdata: exp_word(7)});
        exp_g = 1;
        step();
        clr_start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            chk("starve_rvalid", bus.rvalid, exp_g);
            if (bus.rvalid) rsp_pop("starve");
            exp_w = (k % 9 == 0);
            exp_g = !exp_w;
            chk("starve_gnt", bus.gnt, exp_g);
            chk("starve_clr_wr", mem_req & mem_we, exp_w);
            if (exp_w) begin
                chk("starve_clr_addr", mem_addr, 10 + k / 9 - 1);
                exp_set(10 + k / 9 - 1, 32'h0);
            end
            if (exp_g) rsp_q.push_back('{err: 1'b0, rdata: exp_word(7)});
            step();
        end
        bus.req = 1'b0;
        #1;
        chk("starve_rvalid_end", bus.rvalid, 0);
        chk("starve_done", clr_done, 1);
        step();
        chk("starve_busy_after", clr_busy, 0);
        chk("starve_rsp_left", rsp_q.size(), 0);
        bus_xfer(1'b0, 16'd11, 32'h0, 4'h0);

        // Degenerate clears: zero length and base past the map
        clr_base = 16'd0; clr_len = 17'd0; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        chk("len0_done", clr_done, 1);
        chk("len0_busy", clr_busy, 1);
        chk("len0_mem_req", mem_req, 0);
        step();
        chk("len0_done_clr", clr_done, 0);
        chk("len0_busy_clr", clr_busy, 0);
        clr_base = 16'd2000; clr_len = 17'd5; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        chk("oob_done", clr_done, 1);
        chk("oob_mem_req", mem_req, 0);
        step();
        chk("oob_done_clr", clr_done, 0);

        // Asynchronous reset aborts a running clear
        clr_base = 16'd100; clr_len = 17'd50; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (3) step();
        chk("rstclr_running", mem_req & mem_we, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstclr_busy", clr_busy, 0);
        chk("rstclr_mem_req", mem_req, 0);
        chk("rstclr_done", clr_done, 0);
        step();
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mem_req || clr_busy || clr_done || bus.rvalid) hits++;
        end
        chk("rstclr_quiet", hits, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
